// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write responder:
// - burst encodings
// - response encodings
// - write FSM state type
// - AW error classification helper
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wr_state_e;

    // A burst is unsupported when it is neither FIXED nor INCR,
    // or when its beat size is wider than the data bus.
    function automatic logic aw_is_err(input logic [1:0] burst,
                                       input logic [2:0] size,
                                       input logic [2:0] max_size);
        return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size > max_size);
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational AXI beat-address generator.
// - Beat 0 always uses the AW address as given.
// - Later INCR beats step from the size-aligned base and wrap modulo 2^AW.
// - FIXED (and any unsupported burst) repeats the base address.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] base_i,
    input  logic [2:0]    size_i,
    input  logic [1:0]    burst_i,
    input  logic [8:0]    beat_i,
    output logic [AW-1:0] addr_o
);

    logic [AW-1:0] aligned;
    logic [AW-1:0] offset;

    assign aligned = base_i & ({AW{1'b1}} << size_i);
    assign offset  = AW'(beat_i) << size_i;

    // Select the beat address from the burst type and beat index.
    always_comb begin
        addr_o = base_i;
        if ((beat_i != 9'd0) && (burst_i == BURST_INCR)) begin
            addr_o = aligned + offset;
        end
    end

endmodule

// File: rtl/axi_wr_responder.sv
// AXI4 write-channel responder.
// - Accepts one AW/W burst at a time.
// - Drives a registered memory-write port, one strobe per written beat.
// - Returns a single B response per burst.
// Build option:
// - AXI_WR_RESP_LEN_CHECK_EN enables beat-count checking against awlen.
// - Excess beats are then suppressed and a mismatch reports SLVERR.
module axi_wr_responder
    import axi_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int IDW = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [IDW-1:0]    s_awid,
    input  logic [AW-1:0]     s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic [2:0]        s_awsize,
    input  logic [1:0]        s_awburst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DW-1:0]     s_wdata,
    input  logic [DW/8-1:0]   s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [IDW-1:0]    s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic              o_we,
    output logic [AW-1:0]     o_waddr,
    output logic [DW-1:0]     o_wdata,
    output logic [DW/8-1:0]   o_wstrb
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DW / 8));

    wr_state_e        state_q, state_d;
    logic [IDW-1:0]   id_q;
    logic [AW-1:0]    addr_q;
    logic [7:0]       len_q;
    logic [2:0]       size_q;
    logic [1:0]       burst_q;
    logic             err_q;
    logic [8:0]       cnt_q, cnt_d;

    logic             awready_q, wready_q, bvalid_q;
    logic [IDW-1:0]   bid_q;
    logic [1:0]       bresp_q;
    logic             we_q;
    logic [AW-1:0]    waddr_q;
    logic [DW-1:0]    wdata_q;
    logic [DW/8-1:0]  wstrb_q;

    logic             aw_hs, w_hs, b_hs;
    logic             beat_in_range;
    logic             len_err;
    logic [AW-1:0]    beat_addr;

    assign aw_hs = s_awvalid & awready_q;
    assign w_hs  = s_wvalid & wready_q;
    assign b_hs  = bvalid_q & s_bready;

`ifdef AXI_WR_RESP_LEN_CHECK_EN
    // Beat index cnt_q is zero-based, so the burst is complete when it equals awlen.
    assign beat_in_range = (cnt_q <= {1'b0, len_q});
    assign len_err       = (cnt_q != {1'b0, len_q});
`else
    assign beat_in_range = 1'b1;
    assign len_err       = 1'b0;
`endif

    axi_addr_gen #(
        .AW(AW)
    ) u_addr_gen (
        .base_i  (addr_q),
        .size_i  (size_q),
        .burst_i (burst_q),
        .beat_i  (cnt_q),
        .addr_o  (beat_addr)
    );

    // Next-state logic: IDLE -> DATA on AW, DATA -> RESP on wlast, RESP -> IDLE on B.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (aw_hs)           state_d = ST_DATA;
            ST_DATA: if (w_hs && s_wlast) state_d = ST_RESP;
            ST_RESP: if (b_hs)            state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Beat counter: cleared per burst, saturating at 256 so long bursts cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (aw_hs) begin
            cnt_d = 9'd0;
        end else if (w_hs && (cnt_q != 9'd256)) begin
            cnt_d = cnt_q + 9'd1;
        end
    end

    // State, beat count and the latched AW fields of the current burst.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 9'd0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= 8'd0;
            size_q  <= 3'd0;
            burst_q <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (aw_hs) begin
                id_q    <= s_awid;
                addr_q  <= s_awaddr;
                len_q   <= s_awlen;
                size_q  <= s_awsize;
                burst_q <= s_awburst;
                err_q   <= aw_is_err(s_awburst, s_awsize, MAX_SIZE);
            end
        end
    end

    // Registered handshake flags.
    // - They follow the next state, so awready first rises one edge after reset.
    // - AW and W ready can never overlap.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            awready_q <= (state_d == ST_IDLE);
            wready_q  <= (state_d == ST_DATA);
            bvalid_q  <= (state_d == ST_RESP);
        end
    end

    // B payload: captured on the last beat and held through RESP until accepted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bid_q   <= '0;
            bresp_q <= RESP_OKAY;
        end else if (w_hs && s_wlast) begin
            bid_q   <= id_q;
            bresp_q <= (err_q || len_err) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Memory write port.
    // - One strobe per accepted beat.
    // - Error bursts and out-of-range beats are swallowed without a strobe.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            we_q <= w_hs && !err_q && beat_in_range;
            if (w_hs) begin
                waddr_q <= beat_addr;
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bid     = bid_q;
    assign s_bresp   = bresp_q;
    assign o_we      = we_q;
    assign o_waddr   = waddr_q;
    assign o_wdata   = wdata_q;
    assign o_wstrb   = wstrb_q;

endmodule

// File: tb/tb_axi_wr_responder.sv
// Directed self-checking bench for axi_wr_responder (AW=32, DW=32, IDW=4).
// Length-check expectations follow AXI_WR_RESP_LEN_CHECK_EN when it is defined.
module tb_axi_wr_responder;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IDW = 4;

`ifdef AXI_WR_RESP_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [IDW-1:0]  s_awid;
    logic [AW-1:0]   s_awaddr;
    logic [7:0]      s_awlen;
    logic [2:0]      s_awsize;
    logic [1:0]      s_awburst;
    logic            s_awvalid;
    logic            s_awready;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_wlast;
    logic            s_wvalid;
    logic            s_wready;
    logic [IDW-1:0]  s_bid;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic            o_we;
    logic [AW-1:0]   o_waddr;
    logic [DW-1:0]   o_wdata;
    logic [DW/8-1:0] o_wstrb;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wa_log[$];
    logic [31:0] wd_log[$];
    logic [3:0]  ws_log[$];

    always #5 clk = ~clk;

    axi_wr_responder #(.AW(AW), .DW(DW), .IDW(IDW)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .s_awid    (s_awid),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .s_awsize  (s_awsize),
        .s_awburst (s_awburst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bid     (s_bid),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .o_we      (o_we),
        .o_waddr   (o_waddr),
        .o_wdata   (o_wdata),
        .o_wstrb   (o_wstrb)
    );

    // Log every memory write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (o_we) begin
            wa_log.push_back(o_waddr);
            wd_log.push_back(o_wdata);
            ws_log.push_back(o_wstrb);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, s_awready, 0);
        check({tag, "_wready"},  s_wready,  0);
        check({tag, "_bvalid"},  s_bvalid,  0);
        check({tag, "_bid"},     s_bid,     0);
        check({tag, "_bresp"},   s_bresp,   0);
        check({tag, "_we"},      o_we,      0);
        check({tag, "_waddr"},   o_waddr,   0);
        check({tag, "_wdata"},   o_wdata,   0);
        check({tag, "_wstrb"},   o_wstrb,   0);
    endtask

    // Entered and left at a falling edge.
    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n;
        wa_log.delete();
        wd_log.delete();
        ws_log.delete();
        s_awvalid = 1'b1;
        s_awid    = id;
        s_awaddr  = addr;
        s_awlen   = len;
        s_awsize  = size;
        s_awburst = burst;
        n = 0;
        while (!s_awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("aw_wait", n < 20, 1);
        @(posedge clk);
        @(negedge clk);
        s_awvalid = 1'b0;
        check("wready_after_aw",  s_wready,  1);
        check("awready_after_aw", s_awready, 0);
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb,
                          input logic last, input int gap);
        int n;
        s_wvalid = 1'b0;
        repeat (gap) @(negedge clk);
        s_wvalid = 1'b1;
        s_wdata  = data;
        s_wstrb  = strb;
        s_wlast  = last;
        n = 0;
        while (!s_wready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w_wait", n < 20, 1);
        @(posedge clk);
        @(negedge clk);
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        if (last) begin
            check("wready_after_last", s_wready, 0);
            check("bvalid_after_last", s_bvalid, 1);
        end
    endtask

    task automatic b_wait(input logic [3:0] exp_id, input logic [1:0] exp_resp, input int hold);
        int n;
        s_bready = 1'b0;
        n = 0;
        while (!s_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_wait", n < 20, 1);
        repeat (hold) begin
            @(negedge clk);
            check("bp_bvalid",  s_bvalid,  1);
            check("bp_bid",     s_bid,     exp_id);
            check("bp_bresp",   s_bresp,   exp_resp);
            check("bp_awready", s_awready, 0);
        end
        check("bid",   s_bid,   exp_id);
        check("bresp", s_bresp, exp_resp);
        s_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_bready = 1'b0;
        check("bvalid_after_b",  s_bvalid,  0);
        check("awready_after_b", s_awready, 1);
    endtask

    task automatic chk_wr(input int idx, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
        check($sformatf("wr%0d_present", idx), wa_log.size() > idx, 1);
        if (wa_log.size() > idx) begin
            check($sformatf("wr%0d_addr", idx), wa_log[idx], addr);
            check($sformatf("wr%0d_data", idx), wd_log[idx], data);
            check($sformatf("wr%0d_strb", idx), ws_log[idx], strb);
        end
    endtask

    initial begin
        rst       = 1'b1;
        s_awvalid = 1'b0;
        s_awid    = '0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_awsize  = '0;
        s_awburst = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        s_bready  = 1'b0;

        // Reset values, then awready rises on the first edge after release.
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        check("awready_before_edge", s_awready, 0);
        @(negedge clk);
        check("awready_after_rst", s_awready, 1);

        // INCR burst with B backpressure.
        do_aw(4'h5, 32'h100, 8'd3, 3'd2, 2'd1);
        w_beat(32'hA000_0000, 4'hF, 1'b0, 0);
        w_beat(32'hA000_0001, 4'h3, 1'b0, 0);
        w_beat(32'hA000_0002, 4'hC, 1'b0, 0);
        w_beat(32'hA000_0003, 4'hF, 1'b1, 0);
        check("incr_we_final", o_we, 1);
        b_wait(4'h5, 2'b00, 5);
        check("incr_count", wa_log.size(), 4);
        chk_wr(0, 32'h100, 32'hA000_0000, 4'hF);
        chk_wr(1, 32'h104, 32'hA000_0001, 4'h3);
        chk_wr(2, 32'h108, 32'hA000_0002, 4'hC);
        chk_wr(3, 32'h10C, 32'hA000_0003, 4'hF);

        // FIXED burst with random W gaps.
        do_aw(4'h3, 32'h40, 8'd1, 3'd2, 2'd0);
        w_beat(32'hB000_0000, 4'hF, 1'b0, int'($urandom_range(0, 3)));
        w_beat(32'hB000_0001, 4'hF, 1'b1, int'($urandom_range(0, 3)));
        b_wait(4'h3, 2'b00, 0);
        check("fixed_count", wa_log.size(), 2);
        chk_wr(0, 32'h40, 32'hB000_0000, 4'hF);
        chk_wr(1, 32'h40, 32'hB000_0001, 4'hF);

        // WRAP burst: unsupported, beats consumed silently.
        do_aw(4'h9, 32'h80, 8'd1, 3'd2, 2'd2);
        w_beat(32'hC000_0000, 4'hF, 1'b0, 1);
        w_beat(32'hC000_0001, 4'hF, 1'b1, 2);
        b_wait(4'h9, 2'b10, 0);
        check("wrap_count", wa_log.size(), 0);

        // Oversize beat (8 bytes on a 4-byte bus).
        do_aw(4'hA, 32'h88, 8'd0, 3'd3, 2'd1);
        w_beat(32'hC100_0000, 4'hF, 1'b1, 0);
        b_wait(4'hA, 2'b10, 0);
        check("size_count", wa_log.size(), 0);

        // Short burst: len=3, wlast on beat 2.
        do_aw(4'h1, 32'h300, 8'd3, 3'd2, 2'd1);
        w_beat(32'hD000_0000, 4'hF, 1'b0, 0);
        w_beat(32'hD000_0001, 4'hF, 1'b1, 0);
        b_wait(4'h1, LEN_CHK ? 2'b10 : 2'b00, 0);
        check("short_count", wa_log.size(), 2);
        chk_wr(1, 32'h304, 32'hD000_0001, 4'hF);

        // Long burst: len=1, wlast on beat 3.
        do_aw(4'h2, 32'h200, 8'd1, 3'd2, 2'd1);
        w_beat(32'hE000_0000, 4'hF, 1'b0, 0);
        w_beat(32'hE000_0001, 4'hF, 1'b0, 0);
        w_beat(32'hE000_0002, 4'hF, 1'b1, 0);
        b_wait(4'h2, LEN_CHK ? 2'b10 : 2'b00, 0);
        check("long_count", wa_log.size(), LEN_CHK ? 2 : 3);
        chk_wr(1, 32'h204, 32'hE000_0001, 4'hF);
        if (!LEN_CHK) chk_wr(2, 32'h208, 32'hE000_0002, 4'hF);

        // Unaligned INCR start: later beats step from the aligned base.
        do_aw(4'h6, 32'h103, 8'd2, 3'd2, 2'd1);
        w_beat(32'h1111_0000, 4'h8, 1'b0, 0);
        w_beat(32'h1111_0001, 4'hF, 1'b0, 0);
        w_beat(32'h1111_0002, 4'hF, 1'b1, 0);
        b_wait(4'h6, 2'b00, 0);
        chk_wr(0, 32'h103, 32'h1111_0000, 4'h8);
        chk_wr(1, 32'h104, 32'h1111_0001, 4'hF);
        chk_wr(2, 32'h108, 32'h1111_0002, 4'hF);

        // INCR address wraps modulo 2^32; halfword size.
        do_aw(4'h7, 32'hFFFF_FFFE, 8'd1, 3'd1, 2'd1);
        w_beat(32'h2222_0000, 4'hC, 1'b0, 0);
        w_beat(32'h2222_0001, 4'h3, 1'b1, 0);
        b_wait(4'h7, 2'b00, 0);
        chk_wr(0, 32'hFFFF_FFFE, 32'h2222_0000, 4'hC);
        chk_wr(1, 32'h0000_0000, 32'h2222_0001, 4'h3);

        // Reset asserted in DATA after 2 of 4 beats.
        do_aw(4'hB, 32'h500, 8'd3, 3'd2, 2'd1);
        w_beat(32'h3333_0000, 4'hF, 1'b0, 0);
        w_beat(32'h3333_0001, 4'hF, 1'b0, 0);
        check("pre_rst_we", o_we, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("awready_after_midrst", s_awready, 1);
        check("bvalid_after_midrst", s_bvalid, 0);

        // Next burst completes normally.
        do_aw(4'hC, 32'h600, 8'd1, 3'd2, 2'd1);
        w_beat(32'h4444_0000, 4'hF, 1'b0, 0);
        w_beat(32'h4444_0001, 4'hF, 1'b1, 0);
        b_wait(4'hC, 2'b00, 0);
        check("post_rst_count", wa_log.size(), 2);
        chk_wr(0, 32'h600, 32'h4444_0000, 4'hF);
        chk_wr(1, 32'h604, 32'h4444_0001, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
